pll_lock_seq: RTL and testbench
===============================

Name: pll_lock_seq

Overview:
- Consumer-side companion to the PSRAM rPLL wrapper. Runs on the PLL output clock and watches the PLL lock indication.
- Holds the system reset until lock has been stable, then enforces the PSRAM power-up wait.
- Fires the PSRAM controller's init handshake and reports ready.
- On loss of lock, pulls the design back into reset.

Parameters:
- SYNC_STAGES, 2, flops in the pll_lock_i synchronizer (minimum 2).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before releasing sys_resetn_o (minimum 1).
- PWRUP_WAIT_CYCLES, 8100, cycles between reset release and init_start_o. Default is 150 us at 54 MHz (minimum 1).
- INIT_TIMEOUT_CYCLES, 65535, init watchdog limit. Used only with PLL_INIT_TIMEOUT_EN.

Ports:
- clk  in  1  PLL output clock (clkout).
- resetn  in  1  asynchronous active-low reset.
- pll_lock_i  in  1  PLL LOCK, asynchronous to clk.
- init_done_i  in  1  level from PSRAM controller; high once init is complete.
- sys_resetn_o  out  1  registered active-low reset for downstream logic.
- init_start_o  out  1  one-cycle pulse requesting PSRAM init.
- ready_o  out  1  high while in READY.
- lock_lost_o  out  1  sticky; lock dropped after sys_resetn_o was released.
- state_o  out  3  current state encoding (debug).

Behaviour:
- Reset (resetn=0, async):
  - synchronizer flops = 0; state = S_IDLE (0); counter = 0.
  - sys_resetn_o=0, init_start_o=0, ready_o=0, lock_lost_o=0.
- Synchronizer: lock_s = pll_lock_i after SYNC_STAGES flops. All decisions below use lock_s only.
- Counter: single counter, width = clog2 of the largest count parameter. It clears on every state transition.
- States:
  - S_IDLE (0): unconditionally -> S_WAIT_LOCK on the next cycle.
  - S_WAIT_LOCK (1): sys_resetn_o=0. lock_s=1 -> S_STABLE.
  - S_STABLE (2): the counter increments each cycle lock_s=1.
    - lock_s=0 -> S_WAIT_LOCK, counter cleared.
    - Counter == LOCK_STABLE_CYCLES-1 with lock_s=1 -> S_PWRUP, with sys_resetn_o<=1 in the same registered update.
  - S_PWRUP (3): the counter increments. At PWRUP_WAIT_CYCLES-1 -> S_INIT, with init_start_o<=1 for exactly one cycle.
  - S_INIT (4): waits for init_done_i=1 -> S_READY, with ready_o<=1.
  - S_READY (5): holds. ready_o=1.
- Lock loss: lock_s=0 in S_PWRUP, S_INIT or S_READY has these effects on the next edge:
  - sys_resetn_o=0, ready_o=0, init_start_o=0;
  - lock_lost_o=1;
  - state -> S_WAIT_LOCK.
- lock_lost_o clears only on resetn.
- Priority: lock loss beats counter terminal count and init_done_i in the same cycle.
- init_done_i is ignored outside S_INIT, including if it is already high on entry to S_PWRUP. In S_INIT it is sampled from the cycle after the init_start_o pulse.
- Re-lock after a loss repeats the full sequence: stable count, power-up wait, then a new init_start_o pulse.
- All outputs are registered. There is no combinational path from input to output.
- Latency from a pll_lock_i rise to sys_resetn_o=1 is SYNC_STAGES + 2 + LOCK_STABLE_CYCLES - 1 cycles, with lock held throughout.
- Unused state encodings 6 and 7 -> S_IDLE.

Optional Feature:
- PLL_INIT_TIMEOUT_EN defined:
  - S_INIT counts cycles. If init_done_i has not arrived by INIT_TIMEOUT_CYCLES-1, it returns to S_PWRUP and pulses init_start_o again after PWRUP_WAIT_CYCLES.
  - sys_resetn_o stays 1 during the retry.
- PLL_INIT_TIMEOUT_EN undefined: S_INIT waits indefinitely, and INIT_TIMEOUT_CYCLES is unused.

Test Plan:
Bench parameters: SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, PWRUP_WAIT_CYCLES=16, INIT_TIMEOUT_CYCLES=32.
- Nominal: pll_lock_i=1 from cycle 10, init_done_i=1 three cycles after init_start_o -> sys_resetn_o rises at cycle 21; init_start_o pulses once at cycle 37; ready_o=1 at cycle 41; lock_lost_o=0.
- Glitchy lock: lock high 5 cycles, low 1, then high -> no sys_resetn_o release until 8 consecutive lock_s cycles after the glitch; state passes through 1 again.
- Loss in READY: drop pll_lock_i -> 3 cycles later sys_resetn_o=0, ready_o=0, lock_lost_o=1, state_o=1; re-lock -> full sequence with a second init_start_o pulse; lock_lost_o stays 1.
- Simultaneous: lock_s falls in the same cycle as init_done_i rises in S_INIT -> state 1; ready_o never asserts.
- Async reset mid-S_PWRUP: resetn low for 1 cycle -> all outputs 0 immediately (no clock edge needed); sequence restarts from S_IDLE.
- PLL_INIT_TIMEOUT_EN: init_done_i held 0 -> init_start_o pulses again 32+16 cycles after the first; sys_resetn_o remains 1.

Source files
------------

// File: rtl/pll_lock_seq.sv
// pll_lock_seq: PLL lock sequencer for the PSRAM clock domain.
// Synchronizes PLL LOCK onto clkout and holds the downstream reset until
// lock has been stable. It then waits out the PSRAM power-up time, issues
// a one-cycle init request and reports ready. Losing lock at any point
// after reset release sends the design back into reset.
// Optional build macro PLL_INIT_TIMEOUT_EN adds an init watchdog. When
// init_done_i does not arrive in time, the sequencer repeats the power-up
// wait and the init request.
module pll_lock_seq #(
  parameter int SYNC_STAGES         = 2,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int PWRUP_WAIT_CYCLES   = 8100,
  parameter int INIT_TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock_i,
  input  logic       init_done_i,
  output logic       sys_resetn_o,
  output logic       init_start_o,
  output logic       ready_o,
  output logic       lock_lost_o,
  output logic [2:0] state_o
);

  // One counter serves every timed state, so it is sized for the longest count.
  localparam int MAX_AB = (LOCK_STABLE_CYCLES > PWRUP_WAIT_CYCLES) ?
                          LOCK_STABLE_CYCLES : PWRUP_WAIT_CYCLES;
  localparam int MAX_C  = (MAX_AB > INIT_TIMEOUT_CYCLES) ? MAX_AB : INIT_TIMEOUT_CYCLES;
  localparam int CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CNT_W-1:0] LS_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PWRUP_WAIT_CYCLES - 1);
`ifdef PLL_INIT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] IT_LAST = CNT_W'(INIT_TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_PWRUP     = 3'd3,
    S_INIT      = 3'd4,
    S_READY     = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_sys_rstn;
  logic                   r_init_start;
  logic                   r_ready;
  logic                   r_lock_lost;

  assign w_lock_s     = r_sync[SYNC_STAGES-1];
  assign sys_resetn_o = r_sys_rstn;
  assign init_start_o = r_init_start;
  assign ready_o      = r_ready;
  assign lock_lost_o  = r_lock_lost;
  assign state_o      = r_state;

  // Bring the asynchronous PLL LOCK into the clkout domain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock_i};
    end
  end

  // Sequencer FSM. The outputs are registered here alongside the state.
  // A lock loss is checked first in every released state, so it takes
  // priority over terminal counts and init_done_i.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sys_rstn   <= 1'b0;
      r_init_start <= 1'b0;
      r_ready      <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      r_init_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state    <= S_WAIT_LOCK;
          r_cnt      <= '0;
          r_sys_rstn <= 1'b0;
          r_ready    <= 1'b0;
        end
        S_WAIT_LOCK: begin
          r_cnt      <= '0;
          r_sys_rstn <= 1'b0;
          r_ready    <= 1'b0;
          if (w_lock_s) begin
            r_state <= S_STABLE;
          end else begin
            r_state <= S_WAIT_LOCK;
          end
        end
        S_STABLE: begin
          if (!w_lock_s) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == LS_LAST) begin
            r_state    <= S_PWRUP;
            r_cnt      <= '0;
            r_sys_rstn <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_PWRUP: begin
          if (!w_lock_s) begin
            r_state     <= S_WAIT_LOCK;
            r_cnt       <= '0;
            r_sys_rstn  <= 1'b0;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b1;
          end else if (r_cnt == PW_LAST) begin
            r_state      <= S_INIT;
            r_cnt        <= '0;
            r_init_start <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_INIT: begin
          // init_done_i only counts once the init_start_o pulse has been seen.
          if (!w_lock_s) begin
            r_state     <= S_WAIT_LOCK;
            r_cnt       <= '0;
            r_sys_rstn  <= 1'b0;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b1;
          end else if (init_done_i && !r_init_start) begin
            r_state <= S_READY;
            r_cnt   <= '0;
            r_ready <= 1'b1;
`ifdef PLL_INIT_TIMEOUT_EN
          end else if (r_cnt == IT_LAST) begin
            r_state <= S_PWRUP;
            r_cnt   <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_READY: begin
          if (!w_lock_s) begin
            r_state     <= S_WAIT_LOCK;
            r_cnt       <= '0;
            r_sys_rstn  <= 1'b0;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b1;
          end else begin
            r_state <= S_READY;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_sys_rstn <= 1'b0;
          r_ready    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_seq.sv
// Self-checking bench for pll_lock_seq. It runs directed scenarios and then
// random lock/init_done traffic. Each scenario is checked against a
// timeline model built from lock run lengths and cycle offsets from the
// reset-release edge.
module tb_pll_lock_seq;

  localparam int SS = 2;
  localparam int LS = 8;
  localparam int PW = 16;
  localparam int IT = 32;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pll_lock_i;
  logic       init_done_i;
  logic       sys_resetn_o;
  logic       init_start_o;
  logic       ready_o;
  logic       lock_lost_o;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;
  int tb_edge = 0;
  int n_pulses = 0;

  // Reference model state.
  bit q[$];       // lock samples still inside the synchronizer
  int m_edge;
  int m_run;      // consecutive synchronized-lock edges while still in reset
  int m_r;        // edge at which the current power-up window started
  bit m_started, m_rel, m_ready, m_lost, m_start;

  pll_lock_seq #(
    .SYNC_STAGES(SS), .LOCK_STABLE_CYCLES(LS),
    .PWRUP_WAIT_CYCLES(PW), .INIT_TIMEOUT_CYCLES(IT)
  ) dut (
    .clk(clk), .resetn(resetn), .pll_lock_i(pll_lock_i), .init_done_i(init_done_i),
    .sys_resetn_o(sys_resetn_o), .init_start_o(init_start_o), .ready_o(ready_o),
    .lock_lost_o(lock_lost_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, tb_edge);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < SS; i++) q.push_back(1'b0);
    m_edge = 0; m_run = 0; m_r = 0;
    m_started = 0; m_rel = 0; m_ready = 0; m_lost = 0; m_start = 0;
  endfunction

  // One clock edge of the model. Inputs are the values sampled at that edge.
  task automatic model_edge(input bit lk, input bit dn);
    bit ls;
    int since;
    ls = q.pop_front();
    q.push_back(lk);
    m_edge++;
    m_start = 0;
    if (!m_started) begin
      m_started = 1;
    end else if (!m_rel) begin
      m_run = ls ? m_run + 1 : 0;
      if (m_run == LS + 1) begin
        m_rel = 1; m_r = m_edge; m_run = 0;
      end
    end else begin
      since = m_edge - m_r;
      if (!ls) begin
        m_rel = 0; m_ready = 0; m_lost = 1; m_run = 0;
      end else if (!m_ready) begin
        if (since == PW) m_start = 1;
        else if (since >= PW + 2 && dn) m_ready = 1;
`ifdef PLL_INIT_TIMEOUT_EN
        else if (since == PW + IT) m_r = m_edge;
`endif
      end
    end
  endtask

  function automatic int exp_state();
    if (!m_started) return 0;
    if (!m_rel) return (m_run > 0) ? 2 : 1;
    if (m_ready) return 5;
    return ((m_edge - m_r) < PW) ? 3 : 4;
  endfunction

  // Drive one cycle, advance the model, and compare every output.
  task automatic step(input bit lk, input bit dn);
    @(negedge clk);
    resetn = 1'b1; pll_lock_i = lk; init_done_i = dn;
    model_edge(lk, dn);
    @(posedge clk); #1;
    tb_edge++;
    check_val("sys_resetn", sys_resetn_o, m_rel);
    check_val("init_start", init_start_o, m_start);
    check_val("ready", ready_o, m_ready);
    check_val("lock_lost", lock_lost_o, m_lost);
    check_val("state", state_o, exp_state());
    if (init_start_o) n_pulses++;
  endtask

  // Assert resetn between edges and confirm the outputs clear without a clock.
  task automatic async_reset(input string tag);
    #2;
    resetn = 1'b0; pll_lock_i = 1'b0; init_done_i = 1'b0;
    #1;
    check_val({tag, "_sysrst"}, sys_resetn_o, 0);
    check_val({tag, "_start"}, init_start_o, 0);
    check_val({tag, "_ready"}, ready_o, 0);
    check_val({tag, "_lost"}, lock_lost_o, 0);
    check_val({tag, "_state"}, state_o, 0);
    model_reset();
    n_pulses = 0;
    @(posedge clk); #1;
  endtask

  // Step with fixed inputs until a chosen output event, within a cycle budget.
  task automatic run_until(input string tag, input bit lk, input bit dn, input int sig,
                           input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step(lk, dn);
      if ((sig == 0 && sys_resetn_o) || (sig == 1 && init_start_o) ||
          (sig == 2 && ready_o) || (sig == 3 && state_o == 3'd3)) begin
        at = tb_edge;
        break;
      end
    end
    check_val({tag, "_reached"}, (at >= 0) ? 1 : 0, 1);
  endtask

  initial begin
    int lock_e, rel_e, p_e, p2_e, rdy_e, k;
    bit saw2, saw1_after2, ready_seen, rst_dropped;
    bit lk, dn;
    int seg;

    resetn = 1'b0; pll_lock_i = 1'b0; init_done_i = 1'b0;
    async_reset("por");

    // Nominal bring-up.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    lock_e = tb_edge;
    run_until("nom_rel", 1'b1, 1'b0, 0, 40, rel_e);
    check_val("nom_rel_lat", rel_e - (lock_e - 1), SS + 2 + LS - 1);
    run_until("nom_pulse", 1'b1, 1'b0, 1, 40, p_e);
    check_val("nom_pulse_lat", p_e - rel_e, PW);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    run_until("nom_ready", 1'b1, 1'b1, 2, 10, rdy_e);
    check_val("nom_ready_lat", rdy_e - p_e, 4);
    check_val("nom_pulses", n_pulses, 1);
    check_val("nom_lost", lock_lost_o, 0);

    // Loss of lock while READY, then re-lock.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    check_val("loss_state", state_o, 1);
    check_val("loss_sysrst", sys_resetn_o, 0);
    check_val("loss_ready", ready_o, 0);
    check_val("loss_lost", lock_lost_o, 1);
    run_until("relock_pulse", 1'b1, 1'b0, 1, 60, p2_e);
    check_val("relock_pulses", n_pulses, 2);
    check_val("relock_lost", lock_lost_o, 1);

    // Lock falls in the same cycle that init_done_i rises in S_INIT.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check_val("simul_state", state_o, 1);
    ready_seen = ready_o;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      ready_seen |= ready_o;
    end
    check_val("simul_no_ready", ready_seen, 0);

    // Asynchronous reset during S_PWRUP.
    run_until("mid_pwrup", 1'b1, 1'b0, 3, 40, k);
    step(1'b1, 1'b0);
    check_val("mid_pre_sysrst", sys_resetn_o, 1);
    async_reset("mid");
    step(1'b1, 1'b0);
    check_val("mid_restart_state", state_o, 1);
    run_until("mid_rel", 1'b1, 1'b0, 0, 40, rel_e);

    // Glitchy lock: 5 high, 1 low, then high.
    async_reset("glitch");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    saw2 = 0; saw1_after2 = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      if (state_o == 3'd2) saw2 = 1;
    end
    step(1'b0, 1'b0);
    if (state_o == 3'd2) saw2 = 1;
    step(1'b1, 1'b0);
    lock_e = tb_edge;
    if (saw2 && state_o == 3'd1) saw1_after2 = 1;
    step(1'b1, 1'b0);
    if (saw2 && state_o == 3'd1) saw1_after2 = 1;
    check_val("glitch_back_to_wait", saw1_after2, 1);
    run_until("glitch_rel", 1'b1, 1'b0, 0, 40, rel_e);
    check_val("glitch_rel_lat", rel_e - (lock_e - 1), SS + 2 + LS - 1);

    // Init never completes: watchdog retry or indefinite wait.
    run_until("to_pulse1", 1'b1, 1'b0, 1, 40, p_e);
    rst_dropped = 0;
`ifdef PLL_INIT_TIMEOUT_EN
    run_until("to_pulse2", 1'b1, 1'b0, 1, 100, p2_e);
    check_val("to_retry_lat", p2_e - p_e, IT + PW);
    check_val("to_sysrst", sys_resetn_o, 1);
`else
    for (int i = 0; i < IT + PW + 8; i++) begin
      step(1'b1, 1'b0);
      if (!sys_resetn_o) rst_dropped = 1;
    end
    check_val("to_no_retry", n_pulses, 1);
    check_val("to_still_init", state_o, 4);
`endif
    check_val("to_rst_held", rst_dropped, 0);

    // Random lock and init_done traffic.
    for (int t = 0; t < 4; t++) begin
      async_reset("rnd");
      lk = 1'b0; seg = 0;
      for (int i = 0; i < 400; i++) begin
        if (seg == 0) begin
          lk = ($urandom_range(0, 3) != 0);
          seg = lk ? $urandom_range(1, 80) : $urandom_range(1, 6);
        end
        seg--;
        dn = ($urandom_range(0, 2) == 0);
        step(lk, dn);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
